// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the RV32I EXECUTE stage to a synchronous word-wide RAM. It takes
//   one load or store at a time. Each access becomes one word-aligned RAM
//   transaction with byte write enables. For a load, the unit waits out the
//   RAM read latency. It then returns the extended load data, or the store
//   completion, on a one-cycle response pulse.
//
// Ports
//   clk, resetn        clock; synchronous active-low reset
//   req_valid/ready    request handshake (see below)
//   req_is_store       1 = store, 0 = load
//   req_funct3         RV32I width/sign code
//   req_addr           byte address
//   req_wdata          store data
//   rsp_valid          one-cycle completion pulse
//   rsp_rdata          extended load data; 0 for stores and errors
//   rsp_error          misaligned or illegal funct3, qualified by rsp_valid
//   mem_addr           word-aligned RAM address, held between accesses
//   mem_rstrb          one-cycle read strobe
//   mem_wdata          replicated store data, held between accesses
//   mem_wmask          one-cycle byte write enables
//   mem_rdata          RAM read data, valid MEM_LATENCY cycles after mem_rstrb
//   dbg_state          current FSM state (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//
// Handshake: a request transfers in a cycle where req_valid and req_ready
// are both high. req_ready is high only in IDLE and only while resetn is
// high. There is no buffering, so req_valid is ignored whenever req_ready
// is low. The response is a single-cycle rsp_valid pulse with no
// back-pressure.
module load_store_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rstrb,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic [31:0]           mem_rdata,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  // WAIT lasts MEM_LATENCY cycles; its last cycle is the one where mem_rdata is valid.
  localparam logic [1:0] LAST_WAIT = 2'(MEM_LATENCY - 1);

  state_t                  state_q, state_d;
  logic                    is_store_q, is_store_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [1:0]              off_q, off_d;
  logic                    err_q, err_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic [3:0]              wmask_c;
  logic                    req_bad;

  // Illegal funct3 for the access type, or an address not aligned to the access size.
  function automatic logic bad_request(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic illegal;
    logic misaligned;
    illegal    = st ? (f3[2] || f3[1:0] == 2'b11)
                    : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return illegal || misaligned;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign req_bad = bad_request(req_is_store, req_funct3, req_addr[1:0]);

  always_comb begin
    wmask_c = 4'b0000;
    case (funct3_q[1:0])
      2'b00:   wmask_c = 4'b0001 << off_q;
      2'b01:   wmask_c = off_q[1] ? 4'b1100 : 4'b0011;
      2'b10:   wmask_c = 4'b1111;
      default: wmask_c = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      err_q       <= 1'b0;
      cnt_q       <= 2'd0;
      rdata_q     <= 32'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          off_d      = req_addr[1:0];
          err_d      = req_bad;
          // Rejected requests never reach the RAM, so the held bus values stay put.
          if (!req_bad) begin
            mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            if (req_is_store) begin
              case (req_funct3[1:0])
                2'b00:   mem_wdata_d = {4{req_wdata[7:0]}};
                2'b01:   mem_wdata_d = {2{req_wdata[15:0]}};
                default: mem_wdata_d = req_wdata;
              endcase
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rdata_d = 32'd0;
        if (err_q || is_store_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = 2'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          rdata_d = extract(mem_rdata, funct3_q, off_q);
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE) && resetn;
  assign mem_rstrb = (state_q == ISSUE) && !is_store_q && !err_q;
  assign mem_wmask = ((state_q == ISSUE) && is_store_q && !err_q) ? wmask_c : 4'b0000;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  assign rsp_error = rsp_valid && err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, mem_init;
  logic        v1, v3, st;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;

  logic        rdy1, rv1, re1, rs1, rdy3, rv3, re3, rs3;
  logic [31:0] rd1, ma1, mwd1, mr1, rd3, ma3, mwd3, mr3;
  logic [3:0]  wm1, wm3;
  logic [1:0]  ds1, ds3;

  load_store_unit #(.ADDR_WIDTH(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .resetn(resetn), .req_valid(v1), .req_ready(rdy1),
    .req_is_store(st), .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_error(re1), .mem_addr(ma1),
    .mem_rstrb(rs1), .mem_wdata(mwd1), .mem_wmask(wm1), .mem_rdata(mr1),
    .dbg_state(ds1));

  load_store_unit #(.ADDR_WIDTH(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .resetn(resetn), .req_valid(v3), .req_ready(rdy3),
    .req_is_store(st), .req_funct3(f3), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_error(re3), .mem_addr(ma3),
    .mem_rstrb(rs3), .mem_wdata(mwd3), .mem_wmask(wm3), .mem_rdata(mr3),
    .dbg_state(ds3));

  // ---------------- RAM models ----------------
  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h8001F0A5 : 32'h9E3779B9 * 32'(i + 1);
  endfunction

  logic [31:0] ram [16];
  logic [31:0] p1, q1, q2, q3;
  // Read data is only valid in the one cycle that is exactly the latency after the strobe.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (wm1[j]) ram[ma1[5:2]][8*j +: 8] <= mwd1[8*j +: 8];
        if (wm3[j]) ram[ma3[5:2]][8*j +: 8] <= mwd3[8*j +: 8];
      end
    end
    p1 <= rs1 ? ram[ma1[5:2]] : 32'hDEADBEEF;
    q1 <= rs3 ? ram[ma3[5:2]] : 32'hDEADBEEF;
    q2 <= q1;
    q3 <= q2;
  end
  assign mr1 = p1;
  assign mr3 = q3;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference memory as a byte array; loads/stores computed byte by byte.
  logic [7:0] ref_b [64];

  task automatic ref_init();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++) ref_b[4*i+j] = 8'(init_word(i) >> (8*j));
  endtask

  task automatic ref_eval(input logic s, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] w, output logic err, output logic [31:0] rdata,
                          output logic [3:0] mask, output logic [31:0] mwd);
    logic legal;
    int size, base;
    logic [31:0] v;
    legal = s ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f[1:0];
    err   = !legal || ((a % size) != 0);
    rdata = 0; mask = 0; mwd = 0;
    if (!err) begin
      base = int'(a[5:0]);
      if (s) begin
        for (int i = 0; i < size; i++) begin
          ref_b[base+i] = w[8*i +: 8];
          mask[int'(a[1:0]) + i] = 1'b1;
        end
        for (int j = 0; j < 4; j++) mwd[8*j +: 8] = w[8*(j % size) +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_b[base+i]) << (8*i));
        if (!f[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 1);
        rdata = v;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the selected unit idle; returns at the negedge after the response.
  task automatic run_req(input bit d3, input logic s, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] w, output int lat, output logic [31:0] rdata,
                         output logic err, output int rs_cnt, output int rs_k,
                         output logic [3:0] wm, output int wm_cnt,
                         output logic [31:0] maddr, output logic [31:0] mwd);
    lat = -1; rdata = 0; err = 0; rs_cnt = 0; rs_k = 0; wm = 0; wm_cnt = 0; maddr = 0; mwd = 0;
    chk("req_ready_idle", d3 ? rdy3 : rdy1, 1'b1);
    st = s; f3 = f; addr = a; wdata = w;
    if (d3) v3 = 1'b1; else v1 = 1'b1;
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(negedge clk);
      v1 = 1'b0; v3 = 1'b0;
      if (k == 1) begin
        maddr = d3 ? ma3 : ma1;
        mwd   = d3 ? mwd3 : mwd1;
      end
      if (d3 ? rs3 : rs1) begin rs_cnt++; rs_k = k; end
      if ((d3 ? wm3 : wm1) != 4'b0) begin wm_cnt++; wm = d3 ? wm3 : wm1; end
      if (d3 ? rv3 : rv1) begin
        lat = k; rdata = d3 ? rd3 : rd1; err = d3 ? re3 : re1;
      end
    end
    @(negedge clk);
    chk("rsp_valid_drop", d3 ? rv3 : rv1, 1'b0);
    chk("rsp_rdata_clear", d3 ? rd3 : rd1, 32'd0);
    chk("rsp_error_clear", d3 ? re3 : re1, 1'b0);
  endtask

  task automatic do_txn(input string tag, input logic s, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] w, input logic e_err, input logic [31:0] e_rdata,
                        input logic [3:0] e_mask, input logic [31:0] e_mwd);
    int lat, rs_cnt, rs_k, wm_cnt;
    logic [31:0] rdata, maddr, mwd;
    logic err;
    logic [3:0] wm;
    bit e_load;
    run_req(1'b0, s, f, a, w, lat, rdata, err, rs_cnt, rs_k, wm, wm_cnt, maddr, mwd);
    e_load = !s && !e_err;
    chk($sformatf("%s.latency", tag), 32'(lat), (s || e_err) ? 32'd2 : 32'd3);
    chk($sformatf("%s.rdata", tag), rdata, e_rdata);
    chk($sformatf("%s.error", tag), {31'd0, err}, {31'd0, e_err});
    chk($sformatf("%s.rstrb_count", tag), 32'(rs_cnt), e_load ? 32'd1 : 32'd0);
    if (e_load) chk($sformatf("%s.rstrb_cycle", tag), 32'(rs_k), 32'd1);
    chk($sformatf("%s.wmask_count", tag), 32'(wm_cnt), (s && !e_err) ? 32'd1 : 32'd0);
    chk($sformatf("%s.wmask", tag), {28'd0, wm}, {28'd0, e_mask});
    if (s && !e_err) chk($sformatf("%s.mem_wdata", tag), mwd, e_mwd);
    if (!e_err) chk($sformatf("%s.mem_addr", tag), maddr, {a[31:2], 2'b00});
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_mask;
    logic [31:0] exp_mwd;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rs_cnt, rs_k, wm_cnt, rsp_seen, strobe_seen;
    logic [31:0] rdata, maddr, mwd, e_rd, e_mwd, bb_rd;
    logic err, e_err;
    logic [3:0] wm, e_mask, bb_wm;
    logic [9:0] rb, vb;
    logic s;
    logic [2:0] f;
    logic [31:0] a, w;

    tbl[0]  = '{1'b0, 3'd0, 32'h10, 32'h0,        1'b0, 32'hFFFFFFA5, 4'h0, 32'h0};
    tbl[1]  = '{1'b0, 3'd4, 32'h11, 32'h0,        1'b0, 32'h000000F0, 4'h0, 32'h0};
    tbl[2]  = '{1'b0, 3'd1, 32'h12, 32'h0,        1'b0, 32'hFFFF8001, 4'h0, 32'h0};
    tbl[3]  = '{1'b0, 3'd5, 32'h12, 32'h0,        1'b0, 32'h00008001, 4'h0, 32'h0};
    tbl[4]  = '{1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'h8001F0A5, 4'h0, 32'h0};
    tbl[5]  = '{1'b1, 3'd0, 32'h13, 32'h5A5A5ACC, 1'b0, 32'h0, 4'b1000, 32'hCCCCCCCC};
    tbl[6]  = '{1'b1, 3'd1, 32'h12, 32'hABCD1234, 1'b0, 32'h0, 4'b1100, 32'h12341234};
    tbl[7]  = '{1'b1, 3'd2, 32'h14, 32'hCAFEF00D, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D};
    tbl[8]  = '{1'b0, 3'd2, 32'h12, 32'h0,        1'b1, 32'h0, 4'h0, 32'h0};
    tbl[9]  = '{1'b1, 3'd1, 32'h11, 32'h5555,     1'b1, 32'h0, 4'h0, 32'h0};
    tbl[10] = '{1'b0, 3'd3, 32'h10, 32'h0,        1'b1, 32'h0, 4'h0, 32'h0};
    tbl[11] = '{1'b1, 3'd4, 32'h10, 32'h77,       1'b1, 32'h0, 4'h0, 32'h0};
    tbl[12] = '{1'b0, 3'd2, 32'h10, 32'h0,        1'b0, 32'h1234F0A5, 4'h0, 32'h0};
    tbl[13] = '{1'b0, 3'd0, 32'h13, 32'h0,        1'b0, 32'h00000012, 4'h0, 32'h0};

    // reset state
    resetn = 1'b0; mem_init = 1'b1; v1 = 1'b0; v3 = 1'b0;
    st = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset.req_ready", {31'd0, rdy1}, 32'd0);
    chk("reset.req_ready3", {31'd0, rdy3}, 32'd0);
    chk("reset.rsp_valid", {31'd0, rv1}, 32'd0);
    chk("reset.rsp_rdata", rd1, 32'd0);
    chk("reset.mem_rstrb", {31'd0, rs1}, 32'd0);
    chk("reset.mem_wmask", {28'd0, wm1}, 32'd0);
    chk("reset.mem_addr", ma1, 32'd0);
    chk("reset.mem_wdata", mwd1, 32'd0);
    resetn = 1'b1; mem_init = 1'b0;
    ref_init();
    @(negedge clk);

    // MEM_LATENCY = 3 load
    run_req(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, lat, rdata, err, rs_cnt, rs_k, wm, wm_cnt, maddr, mwd);
    chk("lat3.latency", 32'(lat), 32'd5);
    chk("lat3.rdata", rdata, 32'h8001F0A5);
    chk("lat3.error", {31'd0, err}, 32'd0);
    chk("lat3.rstrb_count", 32'(rs_cnt), 32'd1);
    chk("lat3.rstrb_cycle", 32'(rs_k), 32'd1);
    chk("lat3.mem_addr", maddr, 32'h10);

    // directed table, latency 1
    for (int i = 0; i < 14; i++) begin
      ref_eval(tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata, e_err, e_rd, e_mask, e_mwd);
      do_txn($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
             tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].exp_mask, tbl[i].exp_mwd);
    end

    // back-to-back with req_valid held high: LW 0x10 then SB 0x21
    ref_eval(1'b0, 3'd2, 32'h10, 32'h0, e_err, e_rd, e_mask, e_mwd);
    bb_rd = 32'd0; bb_wm = 4'd0;
    for (int k = 0; k < 10; k++) begin
      rb[k] = rdy1; vb[k] = rv1;
      if (rv1 && k == 3) bb_rd = rd1;
      if (wm1 != 4'd0) bb_wm = wm1;
      if (k == 0) begin st = 1'b0; f3 = 3'd2; addr = 32'h10; wdata = 32'h0; v1 = 1'b1; end
      if (k == 3) begin st = 1'b1; f3 = 3'd0; addr = 32'h21; wdata = 32'h000000E7; end
      if (k == 5) v1 = 1'b0;
      @(negedge clk);
    end
    chk("b2b.ready_pattern", {22'd0, rb}, 32'h391);
    chk("b2b.rsp_pattern", {22'd0, vb}, 32'h048);
    chk("b2b.load_rdata", bb_rd, e_rd);
    ref_eval(1'b1, 3'd0, 32'h21, 32'h000000E7, e_err, e_rd, e_mask, e_mwd);
    chk("b2b.store_wmask", {28'd0, bb_wm}, {28'd0, e_mask});

    // reset during WAIT of a load
    st = 1'b0; f3 = 3'd2; addr = 32'h10; v1 = 1'b1;
    @(negedge clk); v1 = 1'b0;
    @(negedge clk); resetn = 1'b0;
    @(negedge clk);
    chk("midrst.req_ready", {31'd0, rdy1}, 32'd0);
    chk("midrst.rsp_valid", {31'd0, rv1}, 32'd0);
    chk("midrst.rsp_rdata", rd1, 32'd0);
    chk("midrst.rsp_error", {31'd0, re1}, 32'd0);
    chk("midrst.mem_rstrb", {31'd0, rs1}, 32'd0);
    chk("midrst.mem_wmask", {28'd0, wm1}, 32'd0);
    chk("midrst.mem_addr", ma1, 32'd0);
    chk("midrst.mem_wdata", mwd1, 32'd0);
    rsp_seen = 0; strobe_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) resetn = 1'b1;
      @(negedge clk);
      if (rv1) rsp_seen++;
      if (rs1 || wm1 != 4'd0) strobe_seen++;
    end
    chk("midrst.no_rsp", 32'(rsp_seen), 32'd0);
    chk("midrst.no_strobe", 32'(strobe_seen), 32'd0);
    chk("midrst.ready_after", {31'd0, rdy1}, 32'd1);
    ref_eval(1'b0, 3'd2, 32'h10, 32'h0, e_err, e_rd, e_mask, e_mwd);
    do_txn("midrst.reload", 1'b0, 3'd2, 32'h10, 32'h0, e_err, e_rd, e_mask, e_mwd);

    // randomized against the reference model
    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom_range(0, 1));
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      w = $urandom;
      ref_eval(s, f, a, w, e_err, e_rd, e_mask, e_mwd);
      do_txn($sformatf("rnd%0d", i), s, f, a, w, e_err, e_rd, e_mask, e_mwd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
